// File: rtl/loader_pkg.sv
// Shared types and defaults for the instruction SRAM loader.
package loader_pkg;

  localparam logic [7:0] FILL_DEFAULT = 8'h00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    PAD   = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Streams program bytes into the instruction SRAM from address 0, pads the rest with FILL, then releases the CPU.
// LOADER_CHECKSUM_EN: an XOR checksum byte follows the last program byte; a mismatch ends in ERROR.
module prog_loader import loader_pkg::*; #(
  parameter int               ADDR   = 4,
  parameter int               WIDTH  = 8,
  parameter int               LENGTH = 16,
  parameter logic [WIDTH-1:0] FILL   = FILL_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             mem_cs,
  output logic             mem_we,
  output logic [ADDR-1:0]  mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [ADDR:0]    count
);

  localparam logic [ADDR:0]   LEN_CNT   = (ADDR+1)'(LENGTH);
  localparam logic [ADDR:0]   LAST_CNT  = (ADDR+1)'(LENGTH-1);
  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(LENGTH-1);

  state_t           state_q, state_d;
  logic [ADDR:0]    count_q, count_d;
  logic             mem_cs_q, mem_cs_d, mem_we_q, mem_we_d;
  logic [ADDR-1:0]  mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic             cpu_reset_q, cpu_reset_d, busy_q, busy_d;
  logic             done_q, done_d, error_q, error_d;
  logic [ADDR-1:0]  pad_addr;
  logic             xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] csum_q, csum_d;
`endif

  assign in_ready = (state_q == LOAD) || (state_q == CHECK);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mem_cs_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pad_addr    = mem_addr_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = LOAD;
          count_d = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LOAD: begin
        if (xfer) begin
          count_d     = count_q + 1'b1;
          mem_cs_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = count_q[ADDR-1:0];
          mem_wdata_d = in_data;
`ifdef LOADER_CHECKSUM_EN
          csum_d      = csum_q ^ in_data;
          if (in_last) state_d = CHECK;
`else
          if (in_last) state_d = (count_d < LEN_CNT) ? PAD : DONE;
`endif
          else if (count_q == LAST_CNT) state_d = ERROR;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (xfer) state_d = (in_data != csum_q) ? ERROR : ((count_q < LEN_CNT) ? PAD : DONE);
      end
`endif
      PAD: begin
        // The previous strobe always sits at mem_addr_q, so padding continues from the next address.
        mem_cs_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = pad_addr;
        mem_wdata_d = FILL;
        if (pad_addr == LAST_ADDR) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d      = state_d inside {LOAD, CHECK, PAD};
    // done lags DONE entry by one cycle so it never overlaps the final write strobe.
    done_d      = (state_q == DONE) && !start;
    cpu_reset_d = !done_d;
    error_d     = (state_d == ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign count     = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and randomized loads compared against an expected SRAM write list.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset, start, in_valid, in_last;
  logic [7:0] in_data;
  logic       in_ready, mem_cs, mem_we, cpu_reset, busy, done, error;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [4:0] count;

  prog_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .busy(busy),
    .done(done), .error(error), .count(count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_wr_cyc   = 0;
  int done_rise_cyc = 0;
  logic done_prev = 1'b0;
  logic [11:0] got_q[$];
  logic [7:0]  prog_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_cs && mem_we) begin
      got_q.push_back({mem_addr, mem_wdata});
      last_wr_cyc = cyc;
    end
    if (done && !done_prev) done_rise_cyc = cyc;
    done_prev = done;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    got_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 random idle cycles, 2 one idle cycle before every byte
  task automatic send_byte(input logic [7:0] d, input logic last, input int gap_mode);
    int guard = 0;
    if (gap_mode == 2 || (gap_mode == 1 && $urandom_range(0, 2) == 0)) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic run_load(input string name, input bit use_last, input int gap_mode, input bit bad_csum);
    int n = prog_q.size();
    bit exp_err;
    logic [11:0] exp_q[$];
    logic [7:0] x = 8'h00;
    int k = 0;
    do_start();
    for (int i = 0; i < n; i++) begin
      send_byte(prog_q[i], use_last && (i == n - 1), gap_mode);
      x ^= prog_q[i];
    end
    exp_err = !use_last;
`ifdef LOADER_CHECKSUM_EN
    if (use_last) begin
      send_byte(bad_csum ? (x ^ 8'h01) : x, 1'($urandom_range(0, 1)), gap_mode);
      exp_err = bad_csum;
    end
`endif
    in_valid = 1'b0;
    in_last  = 1'b0;
    while (!(done || error) && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (k >= 60) check({name, "_finish_timeout"}, 0, 1);
    repeat (2) @(negedge clk);
    // Reference: program bytes land at 0..n-1; a clean finish fills the remainder with FILL.
    for (int i = 0; i < n; i++) exp_q.push_back({4'(i), prog_q[i]});
    if (!exp_err) for (int a = n; a < 16; a++) exp_q.push_back({4'(a), 8'h00});
    check({name, "_nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_wr%0d", name, i), got_q[i], exp_q[i]);
    check({name, "_done"}, done, !exp_err);
    check({name, "_error"}, error, exp_err);
    check({name, "_cpu_reset"}, cpu_reset, exp_err);
    check({name, "_busy"}, busy, 0);
    check({name, "_in_ready"}, in_ready, 0);
    check({name, "_count"}, count, n);
`ifndef LOADER_CHECKSUM_EN
    if (!exp_err) check({name, "_done_lat"}, done_rise_cyc - last_wr_cyc, 1);
`endif
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_rdy"}, in_ready, 0);
    check({name, "_cs"}, mem_cs, 0);
    check({name, "_we"}, mem_we, 0);
    check({name, "_addr"}, mem_addr, 0);
    check({name, "_wdata"}, mem_wdata, 0);
    check({name, "_cpu_reset"}, cpu_reset, 1);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_error"}, error, 0);
    check({name, "_count"}, count, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;

    prog_q = '{8'h05, 8'h17, 8'h2A};
    run_load("three", 1, 0, 0);

    prog_q.delete();
    for (int i = 0; i < 16; i++) prog_q.push_back(8'(i));
    run_load("full", 1, 0, 0);
    run_load("nolast", 0, 0, 0);

    prog_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_load("toggle", 1, 2, 0);

    // Abort after two of five bytes, then a one-byte program.
    prog_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    do_start();
    send_byte(prog_q[0], 1'b0, 0);
    send_byte(prog_q[1], 1'b0, 0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b0;
    prog_q = '{8'h3C};
    run_load("one", 1, 0, 0);

    prog_q = '{8'h05, 8'h17};
    run_load("csum_ok", 1, 0, 0);
    run_load("csum_bad", 1, 0, 1);

    for (int t = 0; t < 12; t++) begin
      int n = $urandom_range(1, 16);
      bit use_last = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      prog_q.delete();
      for (int i = 0; i < n; i++) prog_q.push_back(8'($urandom));
      run_load($sformatf("rnd%0d", t), use_last, $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
